// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, LSB first, one bit per clock through a single cell.
// Defining SERIAL_SUB_OVF_EN adds a registered two's-complement Overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor cell, returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic br);
        sub_cell = {(~a & b) | (br & ~(a ^ b)), a ^ b ^ br};
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-2:0] res_d;

    // The result register holds WIDTH-1 bits; the final bit is merged in on completion.
    always_comb begin
        {br_d, bit_d} = sub_cell(a_q[0], b_q[0], br_q);
        diff_d        = {bit_d, res_q};
        res_d         = diff_d[WIDTH-1:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= Bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q   <= diff_d;
                        borrow_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it.
                        ovf_q    <= br_q ^ br_d;
`endif
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Overflow = ovf_q;
`endif

endmodule
